// File: rtl/frame_stream_ctrl.sv
// Frame sequencer for the multi-pixel streaming datapath: VSYNC/HSYNC framing,
// per-beat base pixel address, row index and a sticky frame-done flag.
module frame_stream_ctrl #(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int PIX_PER_CLK = 8,
  parameter int START_DELAY = 100,
  parameter int HSYNC_DELAY = 160,
  parameter int ADDR_W      = 19,
  parameter int ROW_W       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              out_ready,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ROW_W-1:0]  row_idx,
  output logic              busy,
  output logic              ctrl_done
);

  localparam int BEATS   = WIDTH / PIX_PER_CLK;
  localparam int COL_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DLY_MAX = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  if (WIDTH % PIX_PER_CLK != 0) begin : g_chk_width
    $error("frame_stream_ctrl: WIDTH must be a multiple of PIX_PER_CLK");
  end
  if (!(PIX_PER_CLK == 1 || PIX_PER_CLK == 2 || PIX_PER_CLK == 4 ||
        PIX_PER_CLK == 8 || PIX_PER_CLK == 16)) begin : g_chk_ppc
    $error("frame_stream_ctrl: PIX_PER_CLK must be 1, 2, 4, 8 or 16");
  end
  if ((64'd1 << ADDR_W) < 64'(WIDTH) * 64'(HEIGHT)) begin : g_chk_addr
    $error("frame_stream_ctrl: ADDR_W too small for WIDTH*HEIGHT");
  end
  if (START_DELAY < 1 || HSYNC_DELAY < 1 || HEIGHT < 1) begin : g_chk_delay
    $error("frame_stream_ctrl: START_DELAY, HSYNC_DELAY and HEIGHT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_GAP   = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DLY_W-1:0]  r_dly;
  logic [DLY_W-1:0]  w_dly_nxt;
  logic [COL_W-1:0]  r_col;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  r_row;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              r_vsync;
  logic              r_data_en;
  logic              r_busy;
  logic              r_done;
  logic              w_vsync_nxt;
  logic              w_data_en_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_beat;
  logic              w_last_col;
  logic              w_last_row;

  // HSYNC is the registered data-phase enable gated by the writer's ready
  assign w_beat     = r_data_en & out_ready;
  assign w_last_col = (r_col == COL_W'(BEATS - 1));
  assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_dly_nxt  = r_dly;
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    w_addr_nxt = r_addr;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next     = S_VSYNC;
          w_dly_nxt  = DLY_W'(START_DELAY - 1);
          w_col_nxt  = COL_W'(0);
          w_row_nxt  = ROW_W'(0);
          w_addr_nxt = ADDR_W'(0);
        end else begin
          w_next = r_state;
        end
      end
      S_VSYNC: begin
        if (r_dly == DLY_W'(0)) begin
          w_next    = S_GAP;
          w_dly_nxt = DLY_W'(HSYNC_DELAY - 1);
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      S_GAP: begin
        if (r_dly == DLY_W'(0)) begin
          w_next = S_DATA;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      S_DATA: begin
        // the final beat leaves pix_addr on the last beat address, never past it
        if (!w_beat) begin
          w_next = S_DATA;
        end else if (!w_last_col) begin
          w_col_nxt  = r_col + COL_W'(1);
          w_addr_nxt = r_addr + ADDR_W'(PIX_PER_CLK);
        end else if (w_last_row) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_GAP;
          w_dly_nxt  = DLY_W'(HSYNC_DELAY - 1);
          w_col_nxt  = COL_W'(0);
          w_row_nxt  = r_row + ROW_W'(1);
          w_addr_nxt = r_addr + ADDR_W'(PIX_PER_CLK);
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it
  always_comb begin
    w_vsync_nxt   = (w_next == S_VSYNC);
    w_data_en_nxt = (w_next == S_DATA);
    w_busy_nxt    = (w_next != S_IDLE) && (w_next != S_DONE);
    w_done_nxt    = (w_next == S_DONE);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dly     <= DLY_W'(0);
      r_col     <= COL_W'(0);
      r_row     <= ROW_W'(0);
      r_addr    <= ADDR_W'(0);
      r_vsync   <= 1'b0;
      r_data_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_dly     <= w_dly_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_addr    <= w_addr_nxt;
      r_vsync   <= w_vsync_nxt;
      r_data_en <= w_data_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign VSYNC     = r_vsync;
  assign HSYNC     = w_beat;
  assign pix_addr  = r_addr;
  assign row_idx   = r_row;
  assign busy      = r_busy;
  assign ctrl_done = r_done;

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Scoreboard bench for frame_stream_ctrl: stimulus pushes expected beats, VSYNC
// lengths and done latencies; negedge monitors pop and compare.
module tb_frame_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       rdy;
  logic       vs;
  logic       hs;
  logic [5:0] addr;
  logic [1:0] row;
  logic       busy;
  logic       done;

  logic       start6;
  logic       rdy6;
  logic       vs6;
  logic       hs6;
  logic [2:0] addr6;
  logic [0:0] row6;
  logic       busy6;
  logic       done6;

  frame_stream_ctrl #(
    .WIDTH(16), .HEIGHT(4), .PIX_PER_CLK(8), .START_DELAY(3), .HSYNC_DELAY(2), .ADDR_W(6)
  ) u_dut (
    .HCLK(clk), .HRESET(rst), .start(start), .out_ready(rdy),
    .VSYNC(vs), .HSYNC(hs), .pix_addr(addr), .row_idx(row), .busy(busy), .ctrl_done(done)
  );

  frame_stream_ctrl #(
    .WIDTH(4), .HEIGHT(2), .PIX_PER_CLK(1), .START_DELAY(3), .HSYNC_DELAY(2), .ADDR_W(3)
  ) u_dut6 (
    .HCLK(clk), .HRESET(rst), .start(start6), .out_ready(rdy6),
    .VSYNC(vs6), .HSYNC(hs6), .pix_addr(addr6), .row_idx(row6), .busy(busy6), .ctrl_done(done6)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int s_edge = 0;
  int s_edge6 = 0;
  int q_addr[$];
  int q_row[$];
  int q_done[$];
  int q_vs[$];
  int q_addr6[$];
  int q_row6[$];
  int q_done6[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Monitor for the main instance
  initial begin
    logic p_done;
    logic p_vs;
    int   vs_cnt;
    int   e;
    p_done = 1'b0;
    p_vs   = 1'b0;
    vs_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rdy) chk("hsync_gated", int'(hs), 0);
      if (hs && rdy) begin
        chk("beat_expected", int'(q_addr.size() > 0), 1);
        if (q_addr.size() > 0) begin
          e = q_addr.pop_front();
          chk("beat_addr", int'(addr), e);
          e = q_row.pop_front();
          chk("beat_row", int'(row), e);
        end
      end
      if (rst) begin
        vs_cnt = 0;
      end else if (vs) begin
        vs_cnt++;
      end else if (p_vs) begin
        chk("vsync_expected", int'(q_vs.size() > 0), 1);
        if (q_vs.size() > 0) chk("vsync_len", vs_cnt, q_vs.pop_front());
        vs_cnt = 0;
      end
      if (done && !p_done) begin
        chk("done_expected", int'(q_done.size() > 0), 1);
        if (q_done.size() > 0) chk("done_latency", edge_n - s_edge, q_done.pop_front());
        chk("busy_low_at_done", int'(busy), 0);
      end
      p_done = done;
      p_vs   = vs;
    end
  end

  // Monitor for the one-pixel-per-clock instance
  initial begin
    logic p_done6;
    int   e;
    p_done6 = 1'b0;
    forever begin
      @(negedge clk);
      if (hs6 && rdy6) begin
        chk("beat6_expected", int'(q_addr6.size() > 0), 1);
        if (q_addr6.size() > 0) begin
          e = q_addr6.pop_front();
          chk("beat6_addr", int'(addr6), e);
          e = q_row6.pop_front();
          chk("beat6_row", int'(row6), e);
        end
      end
      if (done6 && !p_done6) begin
        chk("done6_expected", int'(q_done6.size() > 0), 1);
        if (q_done6.size() > 0) chk("done6_latency", edge_n - s_edge6, q_done6.pop_front());
        chk("busy6_low_at_done", int'(busy6), 0);
      end
      p_done6 = done6;
    end
  end

  task automatic start_frame(input int lat);
    @(posedge clk);
    #1;
    start  = 1'b1;
    s_edge = edge_n + 1;
    for (int i = 0; i < 8; i++) begin
      q_addr.push_back(i * 8);
      q_row.push_back(i / 2);
    end
    q_done.push_back(lat);
    q_vs.push_back(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("vsync_after_start", int'(vs), 1);
    chk("busy_after_start", int'(busy), 1);
    chk("done_after_start", int'(done), 0);
  endtask

  // rel is the start-relative index of the edge that samples the inputs being set
  task automatic run(input int n, input int lo, input int hi, input int restart);
    int rel;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rel   = edge_n + 1 - s_edge;
      rdy   = !(rel >= lo && rel <= hi);
      start = (rel == restart);
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vsync"}, int'(vs), 0);
    chk({tag, "_hsync"}, int'(hs), 0);
    chk({tag, "_addr"}, int'(addr), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    rdy    = 1'b0;
    start6 = 1'b0;
    rdy6   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy = 1'b1;
    #1;
    chk_zero("reset");
    chk("reset6_busy", int'(busy6), 0);
    chk("reset6_done", int'(done6), 0);
    chk("reset6_hsync", int'(hs6), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(4, -1, -1, -1);
    chk("idle_no_hsync", int'(hs), 0);

    // 1: stall-free frame
    start_frame(19);
    run(25, -1, -1, -1);

    // 2: two-cycle stall inside row 1
    chk("done_sticky", int'(done), 1);
    start_frame(21);
    run(25, 11, 12, -1);

    // 3: start during row 2 data is ignored
    start_frame(19);
    run(25, -1, -1, 14);

    // 4: reset in row 2 data
    start_frame(19);
    run(14, -1, -1, -1);
    chk("addr_before_reset", int'(addr), 40);
    rst = 1'b1;
    q_addr.delete();
    q_row.delete();
    q_done.delete();
    q_vs.delete();
    #1;
    chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run(10, -1, -1, -1);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_hsync", int'(hs), 0);
    start_frame(19);
    run(25, -1, -1, -1);

    // 5: start from DONE repeats the frame
    chk("done_before_restart", int'(done), 1);
    start_frame(19);
    run(25, -1, -1, -1);

    // 6: one pixel per clock instance
    @(posedge clk);
    #1;
    start6  = 1'b1;
    s_edge6 = edge_n + 1;
    for (int i = 0; i < 8; i++) begin
      q_addr6.push_back(i);
      q_row6.push_back(i / 4);
    end
    q_done6.push_back(15);
    @(posedge clk);
    #1;
    start6 = 1'b0;
    chk("vsync6_after_start", int'(vs6), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("done6_sticky", int'(done6), 1);

    chk("beats_left", q_addr.size(), 0);
    chk("done_left", q_done.size(), 0);
    chk("vsync_left", q_vs.size(), 0);
    chk("beats6_left", q_addr6.size(), 0);
    chk("done6_left", q_done6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
